fetch_queue_unit: RTL and testbench

Parametrised prefetching fetch stage, the successor to the single-register fetch unit. It owns the fetch PC and issues in-order byte reads to instruction memory through a valid/ready request port. Returned bytes are buffered in a DEPTH-entry queue, and up to two bytes per cycle (opcode plus optional immediate) are presented to the decoder. A redirect (branch, call, return, interrupt, reset vector) flushes the queue and discards responses still in flight.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_queue_unit_if.sv | 23 ++
 rtl/fetch_byte_fifo.sv | 50 +++++
 rtl/fetch_queue_unit.sv | 87 ++++++++
 tb/tb_fetch_queue_unit.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and helpers for the prefetching fetch stage
package fetch_pkg;

    localparam int DEF_AW       = 8;
    localparam int DEF_DW       = 8;
    localparam int DEF_DEPTH    = 4;
    localparam int DEF_RESET_PC = 0;

    localparam logic [1:0] TAKE_NONE = 2'd0;
    localparam logic [1:0] TAKE_ONE  = 2'd1;
    localparam logic [1:0] TAKE_TWO  = 2'd2;

    function automatic logic [1:0] clamp_take(input logic [1:0] take, input logic [1:0] avail);
        return (take > avail) ? avail : take;
    endfunction

endpackage

// File: rtl/fetch_queue_unit_if.sv
// rtl/fetch_queue_unit_if.sv - instruction memory request/response bundle
interface fetch_queue_unit_if
    import fetch_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
);
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;

    modport master (
        output req_valid, req_addr,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_addr,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/fetch_byte_fifo.sv
// rtl/fetch_byte_fifo.sv - circular byte buffer, single push, 0/1/2 pop, flush
module fetch_byte_fifo
    import fetch_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int DEPTH = DEF_DEPTH,
    localparam int PW   = $clog2(DEPTH),
    localparam int OW   = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic [1:0]    pop,
    output logic [OW-1:0] occ,
    output logic [DW-1:0] head0,
    output logic [DW-1:0] head1
);
    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            rd_ptr <= rd_ptr + PW'(pop);
            occ    <= occ + OW'(push) - OW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr] <= push_data;
    end

    assign head0 = mem[rd_ptr];
    assign head1 = mem[rd_ptr + PW'(1)];

endmodule

// File: rtl/fetch_queue_unit.sv
// rtl/fetch_queue_unit.sv - prefetching fetch stage: PCs, request credit, in-flight drop on redirect
module fetch_queue_unit
    import fetch_pkg::*;
#(
    parameter int            AW       = DEF_AW,
    parameter int            DW       = DEF_DW,
    parameter int            DEPTH    = DEF_DEPTH,
    parameter logic [AW-1:0] RESET_PC = AW'(DEF_RESET_PC),
    localparam int           OW       = $clog2(DEPTH) + 1,
    localparam int           CW       = OW + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                redirect_valid,
    input  logic [AW-1:0]       redirect_pc,
    fetch_queue_unit_if.master  mem,
    output logic [1:0]          out_count,
    output logic [DW-1:0]       out_b0,
    output logic [DW-1:0]       out_b1,
    output logic [AW-1:0]       out_pc,
    input  logic [1:0]          out_take
);
    logic [AW-1:0] fetch_pc;
    logic [AW-1:0] head_pc;
    logic [OW-1:0] os;
    logic [OW-1:0] drop;
    logic [OW-1:0] occ;
    logic [DW-1:0] head0;
    logic [DW-1:0] head1;
    logic [CW-1:0] credit_sum;
    logic          accept;
    logic          rsp_live;
    logic          rsp_drop;
    logic [1:0]    take;

    // Credit depends on registered state only, never on req_ready.
    assign credit_sum    = {1'b0, occ} + {1'b0, os};
    assign mem.req_valid = rst_n && !redirect_valid && (credit_sum < CW'(DEPTH));
    assign mem.req_addr  = fetch_pc;

    assign accept   = mem.req_valid && mem.req_ready;
    assign rsp_live = mem.rsp_valid && (drop == '0);
    assign rsp_drop = mem.rsp_valid && (drop != '0);

    assign out_count = (occ >= OW'(2)) ? TAKE_TWO : occ[1:0];
    assign take      = redirect_valid ? TAKE_NONE : clamp_take(out_take, out_count);
    assign out_b0    = (out_count != TAKE_NONE) ? head0 : '0;
    assign out_b1    = (out_count == TAKE_TWO) ? head1 : '0;
    assign out_pc    = head_pc;

    fetch_byte_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (rsp_live && !redirect_valid),
        .push_data (mem.rsp_data),
        .pop       (take),
        .occ       (occ),
        .head0     (head0),
        .head1     (head1)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            head_pc  <= RESET_PC;
            os       <= '0;
            drop     <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            head_pc  <= redirect_pc;
            os       <= '0;
            // Everything still in flight becomes stale; a response arriving now is one of them.
            drop     <= drop + os - OW'(mem.rsp_valid);
        end else begin
            if (accept)
                fetch_pc <= fetch_pc + AW'(1);
            head_pc <= head_pc + AW'(take);
            os      <= os + OW'(accept) - OW'(rsp_live);
            drop    <= drop - OW'(rsp_drop);
        end
    end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb/tb_fetch_queue_unit.sv - scoreboard and vector bench for fetch_queue_unit
module tb_fetch_queue_unit;
    import fetch_pkg::*;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       redirect_valid;
    logic [7:0] redirect_pc;
    logic [1:0] out_count;
    logic [7:0] out_b0;
    logic [7:0] out_b1;
    logic [7:0] out_pc;
    logic [1:0] out_take;

    fetch_queue_unit_if #(.AW(8), .DW(8)) bus ();

    fetch_queue_unit #(
        .AW       (8),
        .DW       (8),
        .DEPTH    (DEPTH),
        .RESET_PC (8'h00)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem            (bus),
        .out_count      (out_count),
        .out_b0         (out_b0),
        .out_b1         (out_b1),
        .out_pc         (out_pc),
        .out_take       (out_take)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] addr;
        int         due;
        bit         stale;
    } infl_t;

    typedef struct {
        logic [1:0] take;
        logic       rv;
        logic [7:0] addr;
        logic [1:0] cnt;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] pc;
    } vec_t;

    int         errors = 0;
    int         checks = 0;
    int         cyc    = 0;
    int         lat    = 1;
    infl_t      infl[$];
    logic [7:0] exp_q[$];
    logic [7:0] acc_log[$];
    logic [7:0] m_fetch = 8'h00;
    logic [7:0] m_head  = 8'h00;
    logic       s_rv;
    logic [7:0] s_addr;
    logic [1:0] s_cnt;
    logic [7:0] s_b0;
    logic [7:0] s_b1;
    logic [7:0] s_pc;
    vec_t       tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int live_os();
        int n = 0;
        foreach (infl[i]) if (!infl[i].stale) n++;
        return n;
    endfunction

    function automatic int tmin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // One clock: present memory response, sample at negedge, advance the reference model at posedge.
    task automatic cycle();
        bit   rsp_pres;
        bit   acc;
        bit   redir;
        int   t;
        int   n;
        infl_t e;
        rsp_pres = (infl.size() > 0) && (infl[0].due <= cyc);
        bus.rsp_valid = rsp_pres;
        bus.rsp_data  = rsp_pres ? infl[0].addr : 8'h00;
        @(negedge clk);
        n = exp_q.size();
        s_rv = bus.req_valid; s_addr = bus.req_addr; s_cnt = out_count;
        s_b0 = out_b0; s_b1 = out_b1; s_pc = out_pc;
        chk("req_valid", s_rv, (!redirect_valid && (n + live_os() < DEPTH)) ? 1 : 0);
        chk("req_addr", s_addr, m_fetch);
        chk("out_count", s_cnt, tmin(n, 2));
        chk("out_pc", s_pc, m_head);
        chk("out_b0", s_b0, (n > 0) ? exp_q[0] : 8'h00);
        chk("out_b1", s_b1, (n > 1) ? exp_q[1] : 8'h00);
        chk("take_legal", (out_take <= out_count) ? 1 : 0, 1);
        chk("credit", (n + live_os() <= DEPTH) ? 1 : 0, 1);
        acc   = bus.req_valid && bus.req_ready;
        redir = redirect_valid;
        t     = out_take;
        @(posedge clk);
        if (redir) begin
            if (rsp_pres) void'(infl.pop_front());
            foreach (infl[i]) infl[i].stale = 1'b1;
            exp_q.delete();
            m_fetch = redirect_pc;
            m_head  = redirect_pc;
        end else begin
            repeat (t) void'(exp_q.pop_front());
            m_head = m_head + 8'(t);
            if (rsp_pres) begin
                e = infl.pop_front();
                if (!e.stale) exp_q.push_back(e.addr);
            end
            if (acc) begin
                infl.push_back('{addr: m_fetch, due: cyc + lat, stale: 1'b0});
                acc_log.push_back(m_fetch);
                m_fetch = m_fetch + 8'd1;
            end
        end
        cyc++;
        #1;
    endtask

    initial begin
        int         want;
        int         seq;
        bit         seen;
        logic [7:0] got;

        tbl[0]  = '{2'd0, 1'b1, 8'h00, 2'd0, 8'h00, 8'h00, 8'h00};
        tbl[1]  = '{2'd0, 1'b1, 8'h01, 2'd0, 8'h00, 8'h00, 8'h00};
        tbl[2]  = '{2'd0, 1'b1, 8'h02, 2'd1, 8'h00, 8'h00, 8'h00};
        tbl[3]  = '{2'd0, 1'b1, 8'h03, 2'd2, 8'h00, 8'h01, 8'h00};
        tbl[4]  = '{2'd0, 1'b0, 8'h04, 2'd2, 8'h00, 8'h01, 8'h00};
        tbl[5]  = '{2'd0, 1'b0, 8'h04, 2'd2, 8'h00, 8'h01, 8'h00};
        tbl[6]  = '{2'd2, 1'b0, 8'h04, 2'd2, 8'h00, 8'h01, 8'h00};
        tbl[7]  = '{2'd1, 1'b1, 8'h04, 2'd2, 8'h02, 8'h03, 8'h02};
        tbl[8]  = '{2'd1, 1'b1, 8'h05, 2'd1, 8'h03, 8'h00, 8'h03};
        tbl[9]  = '{2'd0, 1'b1, 8'h06, 2'd1, 8'h04, 8'h00, 8'h04};
        tbl[10] = '{2'd0, 1'b1, 8'h07, 2'd2, 8'h04, 8'h05, 8'h04};

        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 8'h00; out_take = 2'd0;
        bus.req_ready = 1'b0; bus.rsp_valid = 1'b0; bus.rsp_data = 8'h00;
        #2;
        chk("rst_req_valid", bus.req_valid, 0);
        chk("rst_out_count", out_count, 0);
        chk("rst_out_b0", out_b0, 0);
        chk("rst_out_b1", out_b1, 0);
        chk("rst_out_pc", out_pc, 8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Fill with takes held at 0, then drain a little: cycle-exact vectors.
        bus.req_ready = 1'b1; lat = 1;
        for (int i = 0; i < 11; i++) begin
            out_take = tbl[i].take;
            cycle();
            chk($sformatf("vec%0d_rv", i), s_rv, tbl[i].rv);
            chk($sformatf("vec%0d_addr", i), s_addr, tbl[i].addr);
            chk($sformatf("vec%0d_cnt", i), s_cnt, tbl[i].cnt);
            chk($sformatf("vec%0d_b0", i), s_b0, tbl[i].b0);
            chk($sformatf("vec%0d_b1", i), s_b1, tbl[i].b1);
            chk($sformatf("vec%0d_pc", i), s_pc, tbl[i].pc);
        end

        // Alternating takes of 2 and 1: consumed bytes must be contiguous.
        seq = 4;
        for (int k = 0; k < 40; k++) begin
            want = (k % 2 == 0) ? 2 : 1;
            out_take = 2'(tmin(want, exp_q.size()));
            if (out_take != 0) begin
                got = out_b0;
                chk("seq_b0", got, 8'(seq));
                if (out_take == 2) chk("seq_b1", out_b1, 8'(seq + 1));
                seq += out_take;
            end
            cycle();
        end

        // Three responses in flight, then redirect to 0x40.
        out_take = 2'd0; lat = 3;
        redirect_valid = 1'b1; redirect_pc = 8'h10;
        cycle();
        redirect_valid = 1'b0;
        acc_log.delete();
        repeat (3) cycle();
        chk("inflight_reqs", acc_log.size(), 3);
        redirect_valid = 1'b1; redirect_pc = 8'h40;
        cycle();
        redirect_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            cycle();
            if (s_cnt != 0) seen = 1'b1;
        end
        chk("redir_arrived", seen, 1);
        chk("redir_b0", s_b0, 8'h40);
        chk("redir_pc", s_pc, 8'h40);

        // Address wrap from 0xFE.
        lat = 1;
        redirect_valid = 1'b1; redirect_pc = 8'hFE;
        cycle();
        redirect_valid = 1'b0;
        acc_log.delete();
        repeat (4) cycle();
        chk("wrap_nreq", (acc_log.size() >= 3) ? 1 : 0, 1);
        if (acc_log.size() >= 3) begin
            chk("wrap_req0", acc_log[0], 8'hFE);
            chk("wrap_req1", acc_log[1], 8'hFF);
            chk("wrap_req2", acc_log[2], 8'h00);
        end
        out_take = 2'd1;
        repeat (2) cycle();
        out_take = 2'd0;
        cycle();
        chk("wrap_pc", s_pc, 8'h00);
        chk("wrap_b0", s_b0, 8'h00);

        // Random ready, latency, takes and occasional redirects.
        for (int k = 0; k < 300; k++) begin
            bus.req_ready  = 1'($urandom_range(0, 1));
            lat            = $urandom_range(1, 3);
            out_take       = 2'($urandom_range(0, tmin(2, exp_q.size())));
            redirect_valid = ($urandom_range(0, 39) == 0);
            redirect_pc    = 8'($urandom_range(0, 255));
            cycle();
        end
        redirect_valid = 1'b0;

        // Reset with two requests outstanding.
        bus.req_ready = 1'b1; lat = 3; out_take = 2'd0;
        redirect_valid = 1'b1; redirect_pc = 8'h20;
        cycle();
        redirect_valid = 1'b0;
        repeat (2) cycle();
        bus.req_ready = 1'b0;
        rst_n = 1'b0;
        #2;
        chk("mid_rst_req_valid", bus.req_valid, 0);
        chk("mid_rst_count", out_count, 0);
        chk("mid_rst_addr", bus.req_addr, 8'h00);
        chk("mid_rst_pc", out_pc, 8'h00);
        chk("mid_rst_b0", out_b0, 8'h00);
        infl.delete(); exp_q.delete();
        m_fetch = 8'h00; m_head = 8'h00;
        bus.rsp_valid = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        bus.req_ready = 1'b1; lat = 1;
        cycle();
        chk("post_rst_count", s_cnt, 0);
        chk("post_rst_addr", s_addr, 8'h00);
        for (int k = 0; k < 16; k++) begin
            out_take = 2'(tmin(k % 3, exp_q.size()));
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
